// File: rtl/popcount32.sv
// Pipelined 32-bit population counter built as a 5-level adder tree.
// STAGES (0..3) picks how many of the tree boundaries are registered.
module popcount32 #(
  parameter int STAGES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i,
  output logic        o_valid,
  output logic [5:0]  popcount
);

  localparam bit R2 = (STAGES == 3);
  localparam bit R3 = (STAGES == 2);
  localparam bit R4 = (STAGES == 3);
  localparam bit R5 = (STAGES >= 1);

  if (STAGES < 0 || STAGES > 3) begin : g_bad
    $error("popcount32: STAGES must be 0..3");
  end

  logic [15:0][1:0] s1;
  logic [7:0][2:0]  s2_d, s2_q;
  logic [3:0][3:0]  s3_d, s3_q;
  logic [1:0][4:0]  s4_d, s4_q;
  logic [5:0]       s5_d, s5_q;
  logic             v2, v3, v4, v5;

  always_comb begin
    for (int k = 0; k < 16; k++)
      s1[k] = {1'b0, i[2*k]} + {1'b0, i[2*k+1]};
  end

  always_comb begin
    for (int k = 0; k < 8; k++)
      s2_d[k] = {1'b0, s1[2*k]} + {1'b0, s1[2*k+1]};
  end

  if (R2) begin : g_r2
    always_ff @(posedge clock) begin
      if (reset) begin
        v2   <= 1'b0;
        s2_q <= '0;
      end else begin
        v2 <= i_valid;
        if (i_valid) s2_q <= s2_d;
      end
    end
  end else begin : g_c2
    assign v2   = i_valid;
    assign s2_q = s2_d;
  end

  always_comb begin
    for (int k = 0; k < 4; k++)
      s3_d[k] = {1'b0, s2_q[2*k]} + {1'b0, s2_q[2*k+1]};
  end

  if (R3) begin : g_r3
    always_ff @(posedge clock) begin
      if (reset) begin
        v3   <= 1'b0;
        s3_q <= '0;
      end else begin
        v3 <= v2;
        if (v2) s3_q <= s3_d;
      end
    end
  end else begin : g_c3
    assign v3   = v2;
    assign s3_q = s3_d;
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      s4_d[k] = {1'b0, s3_q[2*k]} + {1'b0, s3_q[2*k+1]};
  end

  if (R4) begin : g_r4
    always_ff @(posedge clock) begin
      if (reset) begin
        v4   <= 1'b0;
        s4_q <= '0;
      end else begin
        v4 <= v3;
        if (v3) s4_q <= s4_d;
      end
    end
  end else begin : g_c4
    assign v4   = v3;
    assign s4_q = s4_d;
  end

  assign s5_d = {1'b0, s4_q[0]} + {1'b0, s4_q[1]};

  if (R5) begin : g_r5
    always_ff @(posedge clock) begin
      if (reset) begin
        v5   <= 1'b0;
        s5_q <= '0;
      end else begin
        v5 <= v4;
        if (v4) s5_q <= s5_d;
      end
    end
  end else begin : g_c5
    // Fully combinational build: clock and reset have no loads.
    logic unused_clk;
    assign unused_clk = clock ^ reset;
    assign v5   = v4;
    assign s5_q = s5_d;
  end

  assign o_valid  = v5;
  assign popcount = s5_q;

endmodule

// File: tb/tb_popcount32.sv
// Bench for popcount32: all four STAGES builds driven in parallel,
// directed vector table followed by a long XNOR-style stream.
module tb_popcount32;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] w;
    logic [5:0]  c;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_word = '0;
  logic [3:0]  ov;
  logic [5:0]  pc [4];

  always #5 clock = ~clock;

  for (genvar s = 0; s < 4; s++) begin : g_dut
    popcount32 #(.STAGES(s)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .i_valid  (i_valid),
      .i        (i_word),
      .o_valid  (ov[s]),
      .popcount (pc[s])
    );
  end

  vec_t        vecs [$];
  logic        hv [$];
  logic [5:0]  hc [$];
  int          cyc = 0;
  int          rl = -1;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [5:0] ref_count(input logic [31:0] w);
    logic [5:0] c = '0;
    for (int b = 0; b < 32; b++) c += {5'b0, w[b]};
    return c;
  endfunction

  task automatic add(input logic r, input logic v,
                     input logic [31:0] w, input logic [5:0] c);
    vec_t e;
    e.rst = r; e.v = v; e.w = w; e.c = c;
    vecs.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, 32'h0, 6'd0);
  endtask

  // Expected output of a STAGES=s build in cycle cyc, from input history.
  task automatic check();
    logic       eov;
    logic [5:0] epc;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        eov = hv[cyc];
        epc = hc[cyc];
      end else begin
        if (rl < 0) continue;
        eov = (cyc - s > rl) && hv[cyc-s];
        epc = '0;
        for (int n = cyc - s; n > rl; n--) begin
          if (hv[n]) begin
            epc = hc[n];
            break;
          end
        end
      end
      n_cmp++;
      if (ov[s] !== eov) begin
        n_bad++;
        $display("FAIL o_valid s=%0d cyc=%0d got %b want %b",
                 s, cyc, ov[s], eov);
      end
      n_cmp++;
      if (pc[s] !== epc) begin
        n_bad++;
        $display("FAIL popcount s=%0d cyc=%0d got %0d want %0d",
                 s, cyc, pc[s], epc);
      end
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [31:0] w, input logic [5:0] c);
    reset   = r;
    i_valid = v;
    i_word  = w;
    hv.push_back(v);
    hc.push_back(c);
    @(negedge clock);
    check();
    if (r) rl = cyc;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] lfsr;
    logic [15:0] cy;
    logic [31:0] a, w;
    logic        v;

    // Reset held 2 cycles with a full word offered; nothing may leak.
    add(1'b1, 1'b1, 32'hFFFF_FFFF, 6'd32);
    add(1'b1, 1'b1, 32'hFFFF_FFFF, 6'd32);
    idle(4);
    // Corner values.
    add(1'b0, 1'b1, 32'h0000_0000, 6'd0);
    add(1'b0, 1'b1, 32'hFFFF_FFFF, 6'd32);
    add(1'b0, 1'b1, 32'hAAAA_AAAA, 6'd16);
    add(1'b0, 1'b1, 32'h8000_0001, 6'd2);
    add(1'b0, 1'b1, 32'h0000_0001, 6'd1);
    idle(4);
    // Back-to-back stream.
    add(1'b0, 1'b1, 32'h0000_000F, 6'd4);
    add(1'b0, 1'b1, 32'h0000_00FF, 6'd8);
    add(1'b0, 1'b1, 32'h0000_FFFF, 6'd16);
    add(1'b0, 1'b1, 32'hFFFF_0000, 6'd16);
    idle(4);
    // Bubbles carrying a loud but invalid word.
    add(1'b0, 1'b1, 32'h0000_0007, 6'd3);
    add(1'b0, 1'b0, 32'hFFFF_FFFF, 6'd32);
    add(1'b0, 1'b0, 32'hFFFF_FFFF, 6'd32);
    add(1'b0, 1'b1, 32'h0000_0001, 6'd1);
    idle(4);
    // Mid-flight reset.
    add(1'b0, 1'b1, 32'h0000_0003, 6'd2);
    add(1'b0, 1'b1, 32'h0000_001F, 6'd5);
    add(1'b0, 1'b1, 32'h0000_F0F0, 6'd8);
    add(1'b1, 1'b0, 32'h0000_0000, 6'd0);
    idle(5);

    @(posedge clock);
    #1;
    for (int k = 0; k < vecs.size(); k++)
      step(vecs[k].rst, vecs[k].v, vecs[k].w, vecs[k].c);

    // BNN-style stream: i = a XNOR b.
    lfsr = 16'hACE1;
    for (int k = 0; k < 10000; k++) begin
      cy   = cyc[15:0];
      a    = {cy - 16'd1, cy};
      w    = ~(a ^ {16'h0, lfsr});
      v    = ($urandom_range(7) != 0);
      step(k == 5000, v, w, ref_count(w));
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
    end
    idle(0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
